lsm_sequencer: RTL

LSM_SEQUENCER -- requirements
Module: lsm_sequencer

---
 rtl/lsm_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/lsm_sequencer.sv
// lsm_sequencer: load/store-multiple sequencer moving one register per cycle
// between the register file and byte-addressed word memory.
// Optional LSM_WRITEBACK_EN: in DONE, write base_addr+2N back to register base_idx.
// Ports: clk/rst (sync active-high); start, is_store, base_addr, reg_mask, base_idx request;
// busy/done status; mem_rd_* / mem_wr_* data memory; rf_rd_* / rf_wr_* register file.
module lsm_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [15:0] base_addr,
  input  logic [7:0]  reg_mask,
  input  logic [2:0]  base_idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_rd_add,
  input  logic [15:0] mem_rd_data,
  output logic        mem_wr_en,
  output logic [15:0] mem_wr_add,
  output logic [15:0] mem_wr_data,
  output logic [2:0]  rf_rd_idx,
  input  logic [15:0] rf_rd_data,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_idx,
  output logic [15:0] rf_wr_data
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic        st;
  logic [15:0] addr;
  logic [7:0]  mask;
  logic [2:0]  idx;
`ifdef LSM_WRITEBACK_EN
  logic [2:0]  bidx;
  always_ff @(posedge clk)
    if (rst) bidx <= '0;
    else if (state == IDLE && start) bidx <= base_idx;
`else
  logic unused_base_idx;
  assign unused_base_idx = ^base_idx;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      st    <= 1'b0;
      addr  <= '0;
      mask  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        st   <= is_store;
        addr <= base_addr;
        mask <= reg_mask;
      end else if (state == RUN) begin
        mask <= mask & (mask - 8'd1);
        addr <= addr + 16'd2;
      end
    end
  end
  always_comb begin
    idx = '0;
    for (int k = 7; k >= 0; k--)
      if (mask[k]) idx = k[2:0];
  end
  // Clearing the lowest set bit leaves zero exactly when this is the last transfer.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ((reg_mask != 8'd0) ? RUN : DONE) : IDLE;
      RUN:     state_nx = ((mask & (mask - 8'd1)) == 8'd0) ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  // In DONE, addr has advanced past every transfer, so it equals base_addr + 2N.
  always_comb begin
    busy        = state != IDLE;
    done        = state == DONE;
    mem_rd_add  = '0;
    mem_wr_en   = 1'b0;
    mem_wr_add  = '0;
    mem_wr_data = '0;
    rf_rd_idx   = '0;
    rf_wr_en    = 1'b0;
    rf_wr_idx   = '0;
    rf_wr_data  = '0;
    if (!rst && state == RUN && st) begin
      rf_rd_idx   = idx;
      mem_wr_en   = 1'b1;
      mem_wr_add  = addr;
      mem_wr_data = rf_rd_data;
    end else if (!rst && state == RUN) begin
      mem_rd_add = addr;
      rf_wr_en   = 1'b1;
      rf_wr_idx  = idx;
      rf_wr_data = mem_rd_data;
    end
`ifdef LSM_WRITEBACK_EN
    else if (!rst && state == DONE) begin
      rf_wr_en   = 1'b1;
      rf_wr_idx  = bidx;
      rf_wr_data = addr;
    end
`endif
  end
endmodule
